// File: rtl/edge_event_arbiter_pkg.sv
// Shared types and defaults for the edge-event arbiter.
// evt_t carries a channel index sized for the largest supported channel count.
package edge_evt_pkg;

  localparam int unsigned N_CH_DEF = 4;
  localparam int unsigned MAX_CH_W = 4;

  typedef struct packed {
    logic [MAX_CH_W-1:0] ch;
    logic                pol;
  } evt_t;

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Event hand-off interface: producer drives valid/ch/pol, consumer drives ready.
interface edge_event_arbiter_if
  import edge_evt_pkg::*;
#(
  parameter int unsigned N_CH = N_CH_DEF
) ();

  localparam int unsigned CH_W = $clog2(N_CH);

  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_ch;
  logic            evt_pol;

  modport master (
    output evt_valid,
    output evt_ch,
    output evt_pol,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_ch,
    input  evt_pol,
    output evt_ready
  );

endinterface

// File: rtl/edge_event_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after i_ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N_CH = 4
) (
  input  logic [N_CH-1:0]         i_req,
  input  logic [$clog2(N_CH)-1:0] i_ptr,
  output logic [N_CH-1:0]         o_gnt,
  output logic [$clog2(N_CH)-1:0] o_gnt_idx,
  output logic                    o_any_gnt
);

  localparam int unsigned CH_W = $clog2(N_CH);

  logic [CH_W-1:0] w_cand;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any_gnt = 1'b0;
    w_cand    = '0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      w_cand = CH_W'((32'(i_ptr) + k) % N_CH);
      if (!o_any_gnt && i_req[w_cand]) begin
        o_any_gnt     = 1'b1;
        o_gnt_idx     = w_cand;
        o_gnt[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge detector with one pending slot per channel, sticky overflow
// flags and a round-robin served valid/ready output register.
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int unsigned N_CH = N_CH_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_CH-1:0]      i_in_sig,
  input  logic [N_CH-1:0]      i_cfg_pos_en,
  input  logic [N_CH-1:0]      i_cfg_neg_en,
  edge_event_arbiter_if.master evt_if,
  output logic [N_CH-1:0]      o_overflow,
  input  logic [N_CH-1:0]      i_ovf_clr
);

  localparam int unsigned CH_W = $clog2(N_CH);
  localparam logic [CH_W-1:0] LastCh = CH_W'(N_CH - 1);

  logic [N_CH-1:0] r_prev;
  logic [N_CH-1:0] r_pend_v;
  logic [N_CH-1:0] r_pend_pol;
  logic [N_CH-1:0] r_overflow;
  logic            r_valid;
  evt_t            r_evt;
  logic [CH_W-1:0] r_rr_ptr;

  logic [N_CH-1:0] w_rise;
  logic [N_CH-1:0] w_fall;
  logic [N_CH-1:0] w_edge;
  logic            w_load;
  logic [N_CH-1:0] w_gnt;
  logic [CH_W-1:0] w_gnt_idx;
  logic            w_any;
  logic [N_CH-1:0] w_take;
  logic [N_CH-1:0] w_pend_v_d;
  logic [N_CH-1:0] w_pend_pol_d;
  logic [N_CH-1:0] w_ovf_set;

  assign w_rise = i_in_sig & ~r_prev & i_cfg_pos_en;
  assign w_fall = ~i_in_sig & r_prev & i_cfg_neg_en;
  assign w_edge = w_rise | w_fall;
  assign w_load = ~r_valid | evt_if.evt_ready;

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_rr_arbiter (
    .i_req     (r_pend_v),
    .i_ptr     (r_rr_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any_gnt (w_any)
  );

  // A slot freed by this cycle's grant can accept a new edge in the same cycle.
  always_comb begin
    w_take       = w_load ? w_gnt : '0;
    w_pend_v_d   = r_pend_v & ~w_take;
    w_pend_pol_d = r_pend_pol;
    w_ovf_set    = w_edge & r_pend_v & ~w_take;
    for (int c = 0; c < N_CH; c++) begin
      if (w_edge[c] && !w_pend_v_d[c]) begin
        w_pend_v_d[c]   = 1'b1;
        w_pend_pol_d[c] = w_rise[c];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev     <= i_in_sig;
      r_pend_v   <= '0;
      r_pend_pol <= '0;
      r_overflow <= '0;
      r_valid    <= 1'b0;
      r_evt      <= '0;
      r_rr_ptr   <= LastCh;
    end else begin
      r_prev     <= i_in_sig;
      r_pend_v   <= w_pend_v_d;
      r_pend_pol <= w_pend_pol_d;
      r_overflow <= (r_overflow & ~i_ovf_clr) | w_ovf_set;
      if (w_load) begin
        r_valid <= w_any;
        if (w_any) begin
          r_evt.ch  <= MAX_CH_W'(w_gnt_idx);
          r_evt.pol <= r_pend_pol[w_gnt_idx];
          r_rr_ptr  <= w_gnt_idx;
        end
      end
    end
  end

  assign evt_if.evt_valid = r_valid;
  assign evt_if.evt_ch    = r_evt.ch[CH_W-1:0];
  assign evt_if.evt_pol   = r_evt.pol;
  assign o_overflow       = r_overflow;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench for edge_event_arbiter: directed vector table, hand sequences
// and randomized traffic against an event-level reference model.
module tb_edge_event_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] in_sig, pos_en, neg_en, ovf_clr, overflow;

  edge_event_arbiter_if #(.N_CH(N)) evt_if ();

  edge_event_arbiter #(
    .N_CH (N)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_in_sig     (in_sig),
    .i_cfg_pos_en (pos_en),
    .i_cfg_neg_en (neg_en),
    .evt_if       (evt_if),
    .o_overflow   (overflow),
    .i_ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: per-channel pending slot, presented event, last grant, flags.
  logic [N-1:0] m_prev, m_pv, m_pp, m_ovf;
  logic         m_valid, m_pol;
  int           m_ch, m_ptr;

  task automatic model_step();
    bit found;
    bit is_r, is_f, set;
    int c;
    if (rst) begin
      m_prev = in_sig; m_pv = '0; m_pp = '0; m_ovf = '0;
      m_valid = 1'b0; m_ch = 0; m_pol = 1'b0; m_ptr = N - 1;
      return;
    end
    if (!m_valid || evt_if.evt_ready) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c = (m_ptr + k) % N;
        if (!found && m_pv[c]) begin
          found = 1'b1; m_valid = 1'b1; m_ch = c; m_pol = m_pp[c];
          m_pv[c] = 1'b0; m_ptr = c;
        end
      end
      if (!found) m_valid = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      is_r = in_sig[i] && !m_prev[i] && pos_en[i];
      is_f = !in_sig[i] && m_prev[i] && neg_en[i];
      set  = 1'b0;
      if (is_r || is_f) begin
        if (m_pv[i]) set = 1'b1;
        else begin m_pv[i] = 1'b1; m_pp[i] = is_r; end
      end
      if (ovf_clr[i]) m_ovf[i] = 1'b0;
      if (set) m_ovf[i] = 1'b1;
    end
    m_prev = in_sig;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] i, input logic [3:0] p, input logic [3:0] n,
                       input logic r, input logic [3:0] c, input logic rs);
    in_sig = i; pos_en = p; neg_en = n; evt_if.evt_ready = r; ovf_clr = c; rst = rs;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_valid"}, 32'(evt_if.evt_valid), 32'(m_valid));
    if (m_valid) begin
      check({tag, "_ch"}, 32'(evt_if.evt_ch), 32'(m_ch));
      check({tag, "_pol"}, 32'(evt_if.evt_pol), 32'(m_pol));
    end
    check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic expect_evt(input string tag, input logic v, input int ch, input logic p,
                            input logic [3:0] ovf);
    check({tag, "_valid"}, 32'(evt_if.evt_valid), 32'(v));
    if (v) begin
      check({tag, "_ch"}, 32'(evt_if.evt_ch), 32'(ch));
      check({tag, "_pol"}, 32'(evt_if.evt_pol), 32'(p));
    end
    check({tag, "_ovf"}, 32'(overflow), 32'(ovf));
  endtask

  typedef struct {
    logic [3:0] in_sig, pos, neg, clr;
    logic       rdy, rst, ev, pol;
    int         ch;
    logic [3:0] ovf;
  } vec_t;

  function automatic vec_t mk(logic [3:0] i, logic [3:0] p, logic [3:0] n, logic r,
                              logic [3:0] c, logic rs, logic ev, int ch, logic pol,
                              logic [3:0] ovf);
    vec_t v;
    v.in_sig = i; v.pos = p; v.neg = n; v.rdy = r; v.clr = c; v.rst = rs;
    v.ev = ev; v.ch = ch; v.pol = pol; v.ovf = ovf;
    return v;
  endfunction

  vec_t tbl[24];

  initial begin
    // Reset; single rise on ch2; ch1 overflow; set-wins clear; neg-enable gating.
    tbl[0]  = mk(4'h0, 4'hF, 4'hF, 1, 4'h0, 1, 0, 0, 0, 4'h0);
    tbl[1]  = mk(4'h0, 4'hF, 4'hF, 1, 4'h0, 0, 0, 0, 0, 4'h0);
    tbl[2]  = mk(4'h4, 4'hF, 4'hF, 1, 4'h0, 0, 0, 0, 0, 4'h0);
    tbl[3]  = mk(4'h4, 4'hF, 4'hF, 1, 4'h0, 0, 1, 2, 1, 4'h0);
    tbl[4]  = mk(4'h4, 4'hF, 4'hF, 1, 4'h0, 0, 0, 0, 0, 4'h0);
    tbl[5]  = mk(4'h6, 4'hF, 4'hF, 0, 4'h0, 0, 0, 0, 0, 4'h0);
    tbl[6]  = mk(4'h4, 4'hF, 4'hF, 0, 4'h0, 0, 1, 1, 1, 4'h0);
    tbl[7]  = mk(4'h6, 4'hF, 4'hF, 0, 4'h0, 0, 1, 1, 1, 4'h2);
    tbl[8]  = mk(4'h6, 4'hF, 4'hF, 1, 4'h0, 0, 1, 1, 0, 4'h2);
    tbl[9]  = mk(4'h6, 4'hF, 4'hF, 1, 4'h0, 0, 0, 0, 0, 4'h2);
    tbl[10] = mk(4'h4, 4'hF, 4'hF, 0, 4'h0, 0, 0, 0, 0, 4'h2);
    tbl[11] = mk(4'h6, 4'hF, 4'hF, 0, 4'h0, 0, 1, 1, 0, 4'h2);
    tbl[12] = mk(4'h4, 4'hF, 4'hF, 0, 4'h2, 0, 1, 1, 0, 4'h2);
    tbl[13] = mk(4'h4, 4'hF, 4'hF, 0, 4'h2, 0, 1, 1, 0, 4'h0);
    tbl[14] = mk(4'h4, 4'hF, 4'hF, 1, 4'h0, 0, 1, 1, 1, 4'h0);
    tbl[15] = mk(4'h4, 4'hF, 4'hF, 1, 4'h0, 0, 0, 0, 0, 4'h0);
    tbl[16] = mk(4'h5, 4'hF, 4'hF, 1, 4'h0, 0, 0, 0, 0, 4'h0);
    tbl[17] = mk(4'h5, 4'hF, 4'hF, 1, 4'h0, 0, 1, 0, 1, 4'h0);
    tbl[18] = mk(4'h4, 4'hF, 4'hE, 1, 4'h0, 0, 0, 0, 0, 4'h0);
    tbl[19] = mk(4'h4, 4'hF, 4'hE, 1, 4'h0, 0, 0, 0, 0, 4'h0);
    tbl[20] = mk(4'h5, 4'hF, 4'hF, 1, 4'h0, 0, 0, 0, 0, 4'h0);
    tbl[21] = mk(4'h4, 4'hF, 4'hF, 1, 4'h0, 0, 1, 0, 1, 4'h0);
    tbl[22] = mk(4'h4, 4'hF, 4'hF, 1, 4'h0, 0, 1, 0, 0, 4'h0);
    tbl[23] = mk(4'h4, 4'hF, 4'hF, 1, 4'h0, 0, 0, 0, 0, 4'h0);

    for (int r = 0; r < 24; r++) begin
      drive(tbl[r].in_sig, tbl[r].pos, tbl[r].neg, tbl[r].rdy, tbl[r].clr, tbl[r].rst);
      step();
      expect_evt($sformatf("tbl%0d", r), tbl[r].ev, tbl[r].ch, tbl[r].pol, tbl[r].ovf);
    end

    // Round-robin bursts on channels 0,1,3, twice.
    drive(4'h0, 4'hF, 4'h0, 1, 4'h0, 1); step();
    drive(4'hB, 4'hF, 4'h0, 1, 4'h0, 0); step();
    expect_evt("rr_a0", 0, 0, 0, 4'h0);
    step(); expect_evt("rr_a1", 1, 0, 1, 4'h0);
    step(); expect_evt("rr_a2", 1, 1, 1, 4'h0);
    step(); expect_evt("rr_a3", 1, 3, 1, 4'h0);
    drive(4'h0, 4'hF, 4'h0, 1, 4'h0, 0); step();
    expect_evt("rr_gap", 0, 0, 0, 4'h0);
    drive(4'hB, 4'hF, 4'h0, 1, 4'h0, 0); step();
    step(); expect_evt("rr_b1", 1, 0, 1, 4'h0);
    step(); expect_evt("rr_b2", 1, 1, 1, 4'h0);
    step(); expect_evt("rr_b3", 1, 3, 1, 4'h0);
    step(); expect_evt("rr_b4", 0, 0, 0, 4'h0);

    // Reset mid-transfer with all lines high and held.
    drive(4'h0, 4'hF, 4'hF, 0, 4'h0, 1); step();
    drive(4'hF, 4'hF, 4'hF, 0, 4'h0, 0); step();
    step(); expect_evt("rst_pre", 1, 0, 1, 4'h0);
    drive(4'hF, 4'hF, 4'hF, 1, 4'h0, 1); step();
    expect_evt("rst_at", 0, 0, 0, 4'h0);
    drive(4'hF, 4'hF, 4'hF, 1, 4'h0, 0);
    for (int k = 0; k < 3; k++) begin
      step(); expect_evt($sformatf("rst_quiet%0d", k), 0, 0, 0, 4'h0);
    end
    drive(4'hE, 4'hF, 4'hF, 1, 4'h0, 0); step();
    step(); expect_evt("rst_after", 1, 0, 0, 4'h0);

    // Single channel toggling every cycle: every event delivered, no overflow.
    drive(4'h0, 4'hF, 4'hF, 1, 4'h0, 1); step();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      in_sig[2] = ~in_sig[2];
      step();
      check_model($sformatf("tog%0d", k));
      if (k > 0) check($sformatf("tog_v%0d", k), 32'(evt_if.evt_valid), 32'd1);
    end

    // Randomized traffic against the model.
    drive(4'h0, 4'hF, 4'hF, 1, 4'h0, 1); step();
    rst = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      if (k % 64 == 0) begin
        pos_en = 4'($urandom);
        neg_en = 4'($urandom);
      end
      in_sig           = 4'($urandom);
      evt_if.evt_ready = ($urandom_range(0, 3) != 0);
      ovf_clr          = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      rst              = ($urandom_range(0, 99) == 0);
      step();
      check_model($sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
